// File: rtl/f_pc_pkg.sv
// Shared types and default constants for the fetch-stage program counter.
// The optional return-address stack is enabled with F_PC_RAS_EN.
package f_pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    EXC  = 2'd2
  } state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam int          EPOCH_W       = 2;

endpackage

// File: rtl/f_pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry, and
// a push that coincides with a pop replaces the top in place.
module f_pc_ras
  import f_pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_addr_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    tp_q, tp_d, wr_idx;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_idx = pop_i ? tp_q : tp_q + 1'b1;
    if (push_i && !pop_i) begin
      tp_d = tp_q + 1'b1;
      if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !push_i) begin
      tp_d  = tp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      if (push_i) mem_q[wr_idx] <= push_addr_i;
    end
  end

  assign top_o   = mem_q[tp_q];
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/f_pc_unit.sv
// Fetch PC with redirect priority, stall hold, exception entry/return and epoch tag.
// Define F_PC_RAS_EN to add the return-address stack as a predicted-return source.
module f_pc_unit
  import f_pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int unsigned      STEP      = 4,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               br_valid_i,
  input  logic [WIDTH-1:0]   br_target_i,
  input  logic               exc_valid_i,
  input  logic               eret_valid_i,
  input  logic [WIDTH-1:0]   epc_i,
  input  logic               ras_push_i,
  input  logic [WIDTH-1:0]   ras_push_addr_i,
  input  logic               ras_pop_i,
  output logic [WIDTH-1:0]   pc_o,
  output logic               pc_valid_o,
  output logic               pc_misalign_o,
  output logic               in_exc_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               ras_empty_o
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic               pc_valid_q, pc_valid_d;
  logic               in_exc_q, in_exc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               redirect;
  logic               ras_pop_acc;
  logic               ras_empty;
  logic [WIDTH-1:0]   ras_top;

`ifdef F_PC_RAS_EN
  f_pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (ras_push_i && (state_q != BOOT)),
    .push_addr_i (ras_push_addr_i),
    .pop_i       (ras_pop_acc),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );
`else
  logic unused_ras;
  assign unused_ras = ^{ras_push_i, ras_push_addr_i, ras_pop_i, ras_pop_acc, ras_top,
                        1'(RAS_DEPTH)};
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_valid_d  = pc_valid_q;
    in_exc_d    = in_exc_q;
    redirect    = 1'b0;
    ras_pop_acc = 1'b0;
    if (state_q == BOOT) begin
      state_d    = RUN;
      pc_valid_d = 1'b1;
    end else if (exc_valid_i && !in_exc_q) begin
      pc_d     = EXC_VEC;
      in_exc_d = 1'b1;
      state_d  = EXC;
      redirect = 1'b1;
    end else if (eret_valid_i && in_exc_q) begin
      pc_d     = epc_i;
      in_exc_d = 1'b0;
      state_d  = RUN;
      redirect = 1'b1;
    end else if (br_valid_i) begin
      pc_d     = br_target_i;
      redirect = 1'b1;
`ifdef F_PC_RAS_EN
    end else if (ras_pop_i && !ras_empty) begin
      pc_d        = ras_top;
      redirect    = 1'b1;
      ras_pop_acc = 1'b1;
`endif
    end else if (en_i) begin
      pc_d = pc_q + WIDTH'(STEP);
    end
    epoch_d = redirect ? epoch_q + 1'b1 : epoch_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      in_exc_q   <= 1'b0;
      epoch_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      in_exc_q   <= in_exc_d;
      epoch_q    <= epoch_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_valid_o    = pc_valid_q;
  assign pc_misalign_o = |pc_q[1:0];
  assign in_exc_o      = in_exc_q;
  assign epoch_o       = epoch_q;
  assign ras_empty_o   = ras_empty;

endmodule
